// File: rtl/cnn_3d_pkg.sv
// rtl/cnn_3d_pkg.sv - shared types and helpers for the 3D CNN pipeline stages
package cnn_3d_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Callers sign-extend into the wide argument and truncate back, so one helper serves any width.
    function automatic logic signed [63:0] relu(input logic signed [63:0] x);
        return x[63] ? 64'sd0 : x;
    endfunction

endpackage

// File: rtl/cnn_3d_relu_maxpool_if.sv
// rtl/cnn_3d_relu_maxpool_if.sv - input/output sample streams of the ReLU + max-pool stage
interface cnn_3d_relu_maxpool_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/cnn_3d_idx_counter.sv
// rtl/cnn_3d_idx_counter.sv - nested col/row/depth/filter raster counter with last flag
module cnn_3d_idx_counter #(
    parameter int SIZE        = 4,
    parameter int NUM_FILTERS = 3,
    parameter int IDX_W       = $clog2(SIZE),
    parameter int FIL_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] col_o,
    output logic [IDX_W-1:0] row_o,
    output logic             dep_lsb_o,
    output logic             last_o
);
    logic [IDX_W-1:0] col_q, col_d, row_q, row_d, dep_q, dep_d;
    logic [FIL_W-1:0] fil_q, fil_d;
    logic             col_max, row_max, dep_max, fil_max;

    assign col_max = (col_q == IDX_W'(SIZE - 1));
    assign row_max = (row_q == IDX_W'(SIZE - 1));
    assign dep_max = (dep_q == IDX_W'(SIZE - 1));
    assign fil_max = (fil_q == FIL_W'(NUM_FILTERS - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        dep_d = dep_q;
        fil_d = fil_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
            dep_d = '0;
            fil_d = '0;
        end else if (adv_i) begin
            col_d = col_max ? '0 : col_q + 1'b1;
            if (col_max) begin
                row_d = row_max ? '0 : row_q + 1'b1;
                if (row_max) begin
                    dep_d = dep_max ? '0 : dep_q + 1'b1;
                    if (dep_max) begin
                        fil_d = fil_max ? '0 : fil_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
            dep_q <= '0;
            fil_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            dep_q <= dep_d;
            fil_q <= fil_d;
        end
    end

    assign col_o     = col_q;
    assign row_o     = row_q;
    assign dep_lsb_o = dep_q[0];
    assign last_o    = col_max && row_max && dep_max && fil_max;
endmodule

// File: rtl/cnn_3d_relu_maxpool.sv
// rtl/cnn_3d_relu_maxpool.sv - ReLU followed by 2x2x2 stride-2 max pooling over raster-ordered result cubes
module cnn_3d_relu_maxpool
    import cnn_3d_pkg::*;
#(
    parameter int IN_SIZE     = 4,
    parameter int NUM_FILTERS = 3,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    cnn_3d_relu_maxpool_if.slave  bus,
    output logic                  done
);
    localparam int POOL  = IN_SIZE / 2;
    localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int ACC_W = (POOL > 1) ? $clog2(POOL * POOL) : 1;
    localparam int ACC_N = 1 << ACC_W;

    if ((IN_SIZE < 2) || (IN_SIZE % 2 != 0)) begin : g_bad_size
        $error("cnn_3d_relu_maxpool: IN_SIZE must be even and at least 2");
    end

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] acc_q [ACC_N];
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_valid_q, out_last_q;

    logic [IDX_W-1:0]         col, row;
    logic                     dep_lsb, cnt_last, cnt_clear;
    logic                     in_ready, accept, drain;
    logic                     win_first, win_final;
    logic [ACC_W-1:0]         acc_idx;
    logic signed [DATA_W-1:0] relu_v, acc_cur, max_v;

    cnn_3d_idx_counter #(
        .SIZE        (IN_SIZE),
        .NUM_FILTERS (NUM_FILTERS),
        .IDX_W       (IDX_W)
    ) u_idx (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (cnt_clear),
        .adv_i     (accept),
        .col_o     (col),
        .row_o     (row),
        .dep_lsb_o (dep_lsb),
        .last_o    (cnt_last)
    );

    assign relu_v    = DATA_W'(relu(64'(bus.in_data)));
    assign acc_idx   = ACC_W'(int'(row >> 1) * POOL + int'(col >> 1));
    assign acc_cur   = acc_q[acc_idx];
    assign max_v     = (relu_v > acc_cur) ? relu_v : acc_cur;
    assign win_first = !dep_lsb && !row[0] && !col[0];
    assign win_final = dep_lsb && row[0] && col[0];
    assign accept    = bus.in_valid && in_ready;
    assign drain     = out_valid_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cnt_clear = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_STREAM;
                    cnt_clear = 1'b1;
                end
            end
            ST_STREAM: begin
                in_ready = !out_valid_q || bus.out_ready;
                if (accept && cnt_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (drain && out_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load always wins over a drain: in_ready guarantees the old output is leaving that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ACC_N; i++) begin
                acc_q[i] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                acc_q[acc_idx] <= win_first ? relu_v : max_v;
            end
            if (accept && win_final) begin
                out_data_q  <= max_v;
                out_valid_q <= 1'b1;
                out_last_q  <= cnt_last;
            end else if (drain) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
endmodule
